// File: rtl/pen_tracker.sv
// pen_tracker: conditions raw IR-camera blob coordinates for display.
// Rejects "no blob" samples, debounces pen presence, smooths each axis with
// a moving average and scales camera space (1024x768) to VGA (640x480).
// Two register stages: FSM/history/sum, then scaled output.
module pen_tracker #(
  parameter int          AVG_LOG2 = 2,
  parameter int          DEBOUNCE = 3,
  parameter logic [9:0]  MISSING  = 10'd1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] cam_x,
  input  logic [9:0] cam_y,
  input  logic       cam_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       pen_down
);

  localparam int         DEPTH = 1 << AVG_LOG2;
  localparam int         SW    = 10 + AVG_LOG2;
  localparam int         PW    = AVG_LOG2;
  localparam logic [3:0] DEB   = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    DRAWING,
    RELEASING
  } state_e;

  // Stage 1 state
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [9:0]      hist_x_q [DEPTH];
  logic [9:0]      hist_x_d [DEPTH];
  logic [9:0]      hist_y_q [DEPTH];
  logic [9:0]      hist_y_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sum_x_q, sum_x_d;
  logic [SW-1:0]   sum_y_q, sum_y_d;
  logic            emit_q, emit_d;

  // Stage 2 state
  logic [9:0]      pix_x_q, pix_x_d;
  logic [9:0]      pix_y_q, pix_y_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pen_down_q, pen_down_d;

  logic            present;
  logic            push;
  logic            load;
  logic [3:0]      cnt_inc;

  // Stage 1: classify the sample, advance the pen FSM, update history and sums
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hist_x_d = hist_x_q;
    hist_y_d = hist_y_q;
    ptr_d    = ptr_q;
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    emit_d   = 1'b0;
    push     = 1'b0;
    load     = 1'b0;
    cnt_inc  = cnt_q + 4'd1;
    present  = (cam_x != MISSING) && (cam_y != MISSING) && (cam_y < 10'd768);

    if (cam_valid) begin
      unique case (state_q)
        IDLE: begin
          if (present) begin
            load = 1'b1;
            if (DEB == 4'd1) begin
              state_d = DRAWING;
              cnt_d   = '0;
              emit_d  = 1'b1;
            end else begin
              state_d = ARMING;
              cnt_d   = 4'd1;
            end
          end
        end
        ARMING: begin
          if (present) begin
            push = 1'b1;
            if (cnt_inc == DEB) begin
              state_d = DRAWING;
              cnt_d   = '0;
              emit_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        DRAWING: begin
          if (present) begin
            push   = 1'b1;
            emit_d = 1'b1;
          end else if (DEB == 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASING;
            cnt_d   = 4'd1;
          end
        end
        RELEASING: begin
          if (present) begin
            state_d = DRAWING;
            cnt_d   = '0;
            push    = 1'b1;
            emit_d  = 1'b1;
          end else if (cnt_inc == DEB) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A new stroke primes the whole window so the first output is the sample itself
    if (load) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_x_d[i] = cam_x;
        hist_y_d[i] = cam_y;
      end
      sum_x_d = SW'(cam_x) << AVG_LOG2;
      sum_y_d = SW'(cam_y) << AVG_LOG2;
    end else if (push) begin
      hist_x_d[ptr_q] = cam_x;
      hist_y_d[ptr_q] = cam_y;
      sum_x_d = sum_x_q - SW'(hist_x_q[ptr_q]) + SW'(cam_x);
      sum_y_d = sum_y_q - SW'(hist_y_q[ptr_q]) + SW'(cam_y);
      ptr_d   = ptr_q + PW'(1);
    end
  end

  // Stage 2: average, scale by 5/8, hold coordinates between strobes
  always_comb begin
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = emit_q;
    pen_down_d  = (state_q == DRAWING) || (state_q == RELEASING);
    if (emit_q) begin
      pix_x_d = 10'((13'(sum_x_q >> AVG_LOG2) * 13'd5) >> 3);
      pix_y_d = 10'((13'(sum_y_q >> AVG_LOG2) * 13'd5) >> 3);
    end
  end

  // Register both stages; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      emit_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_x_q[i] <= '0;
        hist_y_q[i] <= '0;
      end
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      pen_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      emit_q      <= emit_d;
      hist_x_q    <= hist_x_d;
      hist_y_q    <= hist_y_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      pen_down_q  <= pen_down_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_valid = pix_valid_q;
  assign pen_down  = pen_down_q;

endmodule

// File: tb/tb_pen_tracker.sv
// Testbench for pen_tracker: directed vector table, then random stimulus
// checked against a stroke-level reference model.
module tb_pen_tracker;

  localparam int         AVG_LOG2 = 2;
  localparam int         DEBOUNCE = 3;
  localparam logic [9:0] MISSING  = 10'd1023;
  localparam int         DEPTH    = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cam_valid = 1'b0;
  logic [9:0] cam_x = '0;
  logic [9:0] cam_y = '0;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic       pen_down;

  pen_tracker #(
    .AVG_LOG2 (AVG_LOG2),
    .DEBOUNCE (DEBOUNCE),
    .MISSING  (MISSING)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cam_x     (cam_x),
    .cam_y     (cam_y),
    .cam_valid (cam_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pen_down  (pen_down)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit v;
    int x;
    int y;
    bit p;
  } obs_t;

  typedef struct {
    bit         rst;
    bit         cv;
    logic [9:0] x;
    logic [9:0] y;
    obs_t       e;
  } vec_t;

  // Reference model: pen is down once DEBOUNCE present samples in a row are
  // seen, up again after DEBOUNCE missing ones; window is a plain queue.
  bit   m_pen;
  int   m_run;
  int   m_hx[$];
  int   m_hy[$];
  int   m_lx;
  int   m_ly;
  obs_t exp_cur;
  obs_t exp_next;

  function automatic void model(input bit r, input bit v, input int x, input int y);
    bit emit;
    bit pres;
    int sx;
    int sy;
    emit = 1'b0;
    if (r) begin
      m_pen = 1'b0;
      m_run = 0;
      m_hx.delete();
      m_hy.delete();
      m_lx = 0;
      m_ly = 0;
    end else if (v) begin
      pres = (x != MISSING) && (y != MISSING) && (y < 768);
      if (pres) begin
        if (!m_pen && m_run == 0) begin
          m_hx.delete();
          m_hy.delete();
          for (int i = 0; i < DEPTH; i++) begin
            m_hx.push_back(x);
            m_hy.push_back(y);
          end
        end else begin
          void'(m_hx.pop_front());
          void'(m_hy.pop_front());
          m_hx.push_back(x);
          m_hy.push_back(y);
        end
        if (!m_pen) begin
          m_run++;
          if (m_run == DEBOUNCE) begin
            m_pen = 1'b1;
            m_run = 0;
            emit  = 1'b1;
          end
        end else begin
          m_run = 0;
          emit  = 1'b1;
        end
      end else begin
        if (!m_pen) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == DEBOUNCE) begin
            m_pen = 1'b0;
            m_run = 0;
          end
        end
      end
    end
    if (emit) begin
      sx = 0;
      sy = 0;
      foreach (m_hx[i]) sx += m_hx[i];
      foreach (m_hy[i]) sy += m_hy[i];
      m_lx = ((sx / DEPTH) * 5) / 8;
      m_ly = ((sy / DEPTH) * 5) / 8;
    end
    exp_next = '{emit, m_lx, m_ly, m_pen};
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endfunction

  // One clock: drive at negedge, observe 1 time unit after the posedge.
  // Outputs after edge k reflect the sample presented at edge k-1.
  task automatic step(input bit r, input bit v, input logic [9:0] x, input logic [9:0] y,
                      input bit use_model, input obs_t tv, input string tag);
    obs_t req;
    @(negedge clk);
    reset     = r;
    cam_valid = v;
    cam_x     = x;
    cam_y     = y;
    model(r, v, int'(x), int'(y));
    if (r) begin
      exp_cur  = '{1'b0, 0, 0, 1'b0};
      exp_next = '{1'b0, 0, 0, 1'b0};
    end
    @(posedge clk);
    #1;
    req = use_model ? exp_cur : tv;
    chk({tag, ".pix_valid"}, int'(pix_valid), int'(req.v));
    chk({tag, ".pix_x"},     int'(pix_x),     req.x);
    chk({tag, ".pix_y"},     int'(pix_y),     req.y);
    chk({tag, ".pen_down"},  int'(pen_down),  int'(req.p));
    exp_cur = exp_next;
  endtask

  vec_t tbl[$];

  task automatic add(input bit rst, input bit cv, input int x, input int y,
                     input bit ev, input int ex, input int ey, input bit ep);
    vec_t t;
    t.rst = rst;
    t.cv  = cv;
    t.x   = 10'(x);
    t.y   = 10'(y);
    t.e   = '{ev, ex, ey, ep};
    tbl.push_back(t);
  endtask

  initial begin
    bit         mode;
    bit         r;
    bit         v;
    logic [9:0] x;
    logic [9:0] y;
    obs_t       dummy;

    exp_cur  = '{1'b0, 0, 0, 1'b0};
    exp_next = '{1'b0, 0, 0, 1'b0};
    dummy    = '{1'b0, 0, 0, 1'b0};

    // rst cv  x     y     ev  ex   ey   pen
    add(1, 0,    0,    0,  0,   0,   0, 0);
    // three spaced samples arm and then start a stroke
    add(0, 1,  512,  384,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 1,  512,  384,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);
    add(0, 1,  512,  384,  0,   0,   0, 0);
    add(0, 0,    0,    0,  1, 320, 240, 1);
    // moving average converges toward 520
    add(0, 1,  520,  384,  0, 320, 240, 1);
    add(0, 0,    0,    0,  1, 321, 240, 1);
    add(0, 1,  520,  384,  0, 321, 240, 1);
    add(0, 1,  520,  384,  1, 322, 240, 1);
    add(0, 1,  520,  384,  1, 323, 240, 1);
    add(0, 0,    0,    0,  1, 325, 240, 1);
    // single dropout, then resume with pre-dropout history
    add(0, 1, 1023, 1023,  0, 325, 240, 1);
    add(0, 0,    0,    0,  0, 325, 240, 1);
    add(0, 1,  512,  384,  0, 325, 240, 1);
    add(0, 0,    0,    0,  1, 323, 240, 1);
    // three missing in a row lift the pen (third one is y out of range)
    add(0, 1, 1023, 1023,  0, 323, 240, 1);
    add(0, 1, 1023, 1023,  0, 323, 240, 1);
    add(0, 1,    0,  800,  0, 323, 240, 1);
    add(0, 0,    0,    0,  0, 323, 240, 0);
    // 2 present, 1 missing, 2 present: no stroke; third present after rearm starts one
    add(0, 1,  100,  100,  0, 323, 240, 0);
    add(0, 1,  100,  100,  0, 323, 240, 0);
    add(0, 1, 1023,    5,  0, 323, 240, 0);
    add(0, 1,  100,  100,  0, 323, 240, 0);
    add(0, 1,  100,  100,  0, 323, 240, 0);
    add(0, 0,    0,    0,  0, 323, 240, 0);
    add(0, 1,  100,  100,  0, 323, 240, 0);
    add(0, 0,    0,    0,  1,  62,  62, 1);
    // back-to-back maximum coordinates, reset wins over a coincident sample
    add(1, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 1, 1022,  767,  1, 638, 479, 1);
    add(0, 1, 1022,  767,  1, 638, 479, 1);
    add(1, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 1, 1022,  767,  0,   0,   0, 0);
    add(0, 0,    0,    0,  0,   0,   0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].cv, tbl[i].x, tbl[i].y, 1'b0, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Randomized phase against the reference model
    step(1'b1, 1'b0, '0, '0, 1'b1, dummy, "rnd_reset");
    mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0)) begin
        x = 10'($urandom_range(0, 1022));
        y = 10'($urandom_range(0, 767));
      end else begin
        case ($urandom_range(0, 2))
          0: begin x = MISSING; y = 10'($urandom_range(0, 767)); end
          1: begin x = 10'($urandom_range(0, 1022)); y = MISSING; end
          default: begin x = 10'($urandom_range(0, 1022)); y = 10'($urandom_range(768, 1022)); end
        endcase
      end
      step(r, v, x, y, 1'b1, dummy, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
